// File: rtl/aes_word_packer.sv
// Packs four 32-bit words into one 16-byte block. Each block goes to the 16-byte
// state register with a wr_en strobe, then waits for that register's reg_full acknowledge.
module aes_word_packer #(
    parameter int BYTE_SWAP = 0,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic                 in_clear,
    input  logic                 reg_full,
    output logic                 wr_en,
    output logic [15:0][7:0]     o,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [1:0]       wcnt_reg, wcnt_next;
    logic             seen_reg, seen_next;
    logic [CNT_W-1:0] blk_cnt_reg, blk_cnt_next;
    logic [15:0][7:0] o_reg;
    logic [3:0][7:0]  word_bytes;
    logic             accept;

    // word_bytes[j] is the byte that lands at block offset 4*wcnt + j
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_map
            if (BYTE_SWAP != 0) begin : g_lsb_first
                assign word_bytes[gi] = in_data[8*gi +: 8];
            end else begin : g_msb_first
                assign word_bytes[gi] = in_data[31-8*gi -: 8];
            end
        end
    endgenerate

    // in_clear outranks in_valid, so a word presented together with it is dropped
    assign accept = (state_reg == ST_FILL) && in_valid && !in_clear;

    always_comb begin
        state_next   = state_reg;
        wcnt_next    = wcnt_reg;
        seen_next    = seen_reg;
        blk_cnt_next = blk_cnt_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_FILL;
            ST_FILL: begin
                if (in_clear) begin
                    wcnt_next = 2'd0;
                end else if (accept) begin
                    wcnt_next = wcnt_reg + 2'd1;
                    if (wcnt_reg == 2'd3) begin
                        state_next = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (!reg_full) begin
                    state_next = ST_WAIT;
                    seen_next  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (reg_full) begin
                    seen_next = 1'b1;
                end else if (seen_reg) begin
                    state_next   = ST_FILL;
                    blk_cnt_next = blk_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            wcnt_reg    <= 2'd0;
            seen_reg    <= 1'b0;
            blk_cnt_reg <= '0;
            o_reg       <= '0;
        end else begin
            state_reg   <= state_next;
            wcnt_reg    <= wcnt_next;
            seen_reg    <= seen_next;
            blk_cnt_reg <= blk_cnt_next;
            if (accept) begin
                for (int j = 0; j < 4; j++) begin
                    o_reg[{wcnt_reg, j[1:0]}] <= word_bytes[j];
                end
            end
        end
    end

    // Control outputs are pure state decodes: no path from in_valid or reg_full
    assign in_ready = (state_reg == ST_FILL);
    assign wr_en    = (state_reg == ST_SEND);
    assign busy     = (state_reg == ST_SEND) || (state_reg == ST_WAIT);
    assign blk_cnt  = blk_cnt_reg;
    assign o        = o_reg;

endmodule

// File: tb/tb_aes_word_packer.sv
// Bench for aes_word_packer: an MSB-first/16-bit-count instance and an LSB-first/4-bit-count
// instance share stimulus; a downstream register model drives reg_full and a scoreboard checks blocks.
module tb_aes_word_packer;

    typedef logic [15:0][7:0] blk_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_clear = 1'b0;
    logic        reg_full = 1'b0;
    logic        in_ready, wr_en, busy;
    blk_t        o;
    logic [15:0] blk_cnt;
    logic        in_ready_s, wr_en_s, busy_s;
    blk_t        o_s;
    logic [3:0]  blk_cnt_s;

    int total = 0;
    int bad = 0;

    blk_t        q0[$];
    blk_t        q1[$];
    logic [31:0] wb[4];
    int          nw = 0;
    int          exp_blocks = 0;
    int          force_full = 0;
    int          pulses = 0;
    int          wr_cycles = 0;
    logic        pend = 1'b0;
    logic        wr_prev = 1'b0;
    logic        busy_prev = 1'b0;
    blk_t        o_snap;

    always #5 clk = ~clk;

    aes_word_packer #(.BYTE_SWAP(0), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_clear(in_clear), .reg_full(reg_full), .wr_en(wr_en),
        .o(o), .busy(busy), .blk_cnt(blk_cnt)
    );

    aes_word_packer #(.BYTE_SWAP(1), .CNT_W(4)) dut_swap (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_clear(in_clear), .reg_full(reg_full), .wr_en(wr_en_s),
        .o(o_s), .busy(busy_s), .blk_cnt(blk_cnt_s)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic blk_t mk_blk(input int swap);
        blk_t b;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                b[4*k+j] = (swap != 0) ? wb[k][8*j +: 8] : wb[k][31-8*j -: 8];
            end
        end
        return b;
    endfunction

    // Downstream register model plus per-cycle monitors, all sampled on the falling edge
    always @(negedge clk) begin
        if (!resetn) begin
            reg_full = 1'b0;
            pend     = 1'b0;
        end else if (wr_en) begin
            if (force_full > 0) begin
                reg_full = 1'b1;
                force_full--;
            end else begin
                reg_full = 1'b0;
                pend     = 1'b1;
                if (q0.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    chk("block_msb", o, q0.pop_front());
                    chk("block_lsb", o_s, q1.pop_front());
                    exp_blocks++;
                    $display("block %0d written: %h", exp_blocks, o);
                end
            end
        end else if (pend) begin
            reg_full = 1'b1;
            pend     = 1'b0;
        end else begin
            reg_full = 1'b0;
        end
        if (wr_en && !wr_prev) pulses++;
        if (wr_en) wr_cycles++;
        if (wr_en && in_ready) chk("ready_wr_exclusive", 1, 0);
        if (busy && !busy_prev) o_snap = o;
        else if (busy) chk("o_stable", o, o_snap);
        wr_prev   = wr_en;
        busy_prev = busy;
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge
    task automatic put_word(input logic [31:0] d);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else begin
            $display("word %h accepted", d);
            wb[nw] = d;
            nw++;
            if (nw == 4) begin
                q0.push_back(mk_blk(0));
                q1.push_back(mk_blk(1));
                nw = 0;
            end
        end
    endtask

    task automatic put_block(input logic [31:0] a, b, c, d);
        put_word(a);
        put_word(b);
        put_word(c);
        put_word(d);
        in_valid = 1'b0;
    endtask

    task automatic wait_fill(input string tag);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("fill_timeout", 0, 1);
        chk({tag, "_blk_cnt"}, blk_cnt, exp_blocks);
        chk({tag, "_blk_cnt_w4"}, blk_cnt_s, exp_blocks % 16);
    endtask

    task automatic do_reset(input string tag);
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_clear = 1'b0;
        @(negedge clk);
        nw = 0;
        q0.delete();
        q1.delete();
        exp_blocks = 0;
        force_full = 0;
        chk({tag, "_rst_o"}, o, 0);
        chk({tag, "_rst_blk_cnt"}, blk_cnt, 0);
        chk({tag, "_rst_in_ready"}, in_ready, 0);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_wr_en"}, wr_en, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_after_release"}, in_ready, 1);
        $display("reset %s done", tag);
    endtask

    initial begin
        int p0;
        @(negedge clk);
        do_reset("init");

        // Back-to-back block
        p0 = pulses;
        put_block(32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);
        wait_fill("b2b");
        chk("b2b_pulses", pulses - p0, 1);
        chk("b2b_o0", o[0], 8'h00);
        chk("b2b_o15", o[15], 8'h0F);
        chk("swap_o0", o_s[0], 8'h03);
        chk("swap_o3", o_s[3], 8'h00);
        chk("swap_o15", o_s[15], 8'h0C);

        // Gapped words, then in_valid held with junk through SEND/WAIT
        put_word(32'h00010203);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        put_word(32'h04050607);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        put_word(32'h08090A0B);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        put_word(32'h0C0D0E0F);
        in_data = 32'hDEADBEEF;
        chk("hold_ready_send", in_ready, 0);
        @(negedge clk);
        chk("hold_ready_wait1", in_ready, 0);
        @(negedge clk);
        chk("hold_ready_wait2", in_ready, 0);
        @(negedge clk);
        chk("hold_ready_fill", in_ready, 1);
        in_valid = 1'b0;
        chk("gap_blk_cnt", blk_cnt, exp_blocks);
        chk("gap_o_kept", o, 128'h0F0E0D0C0B0A09080706050403020100);

        // Clear over a partial block, with a word presented alongside
        p0 = pulses;
        put_word(32'h11111111);
        put_word(32'h22222222);
        in_clear = 1'b1;
        in_data  = 32'h33333333;
        @(negedge clk);
        in_clear = 1'b0;
        nw = 0;
        put_block(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_fill("clear");
        chk("clear_pulses", pulses - p0, 1);
        chk("clear_o", o, {128{1'b1}});

        // reg_full held high for 3 cycles while in SEND
        p0 = pulses;
        wr_cycles = 0;
        force_full = 3;
        put_block(32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3);
        wait_fill("force");
        chk("force_wr_cycles", wr_cycles, 4);
        chk("force_pulses", pulses - p0, 1);

        // Reset while in WAIT
        put_block(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
        for (int i = 0; i < 20 && !(busy && !wr_en); i++) @(negedge clk);
        chk("reached_wait", busy && !wr_en, 1);
        do_reset("wait");
        p0 = pulses;
        repeat (10) @(negedge clk);
        chk("wait_no_wr", pulses - p0, 0);

        // Reset after two words
        put_word(32'h12345678);
        put_word(32'h9ABCDEF0);
        in_valid = 1'b0;
        do_reset("partial");
        p0 = pulses;
        repeat (10) @(negedge clk);
        chk("partial_no_wr", pulses - p0, 0);

        // 300 blocks of random data
        for (int n = 0; n < 300; n++) begin
            put_block($urandom, $urandom, $urandom, $urandom);
            wait_fill("rand");
        end
        chk("cnt_300", blk_cnt, 16'd300);
        chk("cnt_wrap_w4", blk_cnt_s, 4'd12);
        chk("queue_empty", q0.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
